// File: rtl/gf_reduce_sched_if.sv
// Bundle of the request, datapath and response signals of gf_reduce_sched.
// slave is the scheduler's view; master is the surrounding system's view.
interface gf_reduce_sched_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4
) ();
    localparam int GW = $clog2(DATA_WIDTH) + 1;
    localparam int IW = $clog2(NUM_REQ);

    logic                              enable;
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ*GW-1:0]             req_grade;
    logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_polyn;
    logic [NUM_REQ*2*DATA_WIDTH-1:0]   req_data;
    logic                              red_enable;
    logic [GW-1:0]                     red_grade;
    logic [DATA_WIDTH:0]               red_polyn;
    logic [2*DATA_WIDTH-1:0]           red_reduc;
    logic [DATA_WIDTH-1:0]             red_out;
    logic                              rsp_valid;
    logic                              rsp_ready;
    logic [IW-1:0]                     rsp_id;
    logic [DATA_WIDTH-1:0]             rsp_data;
    logic                              rsp_err;
    logic                              busy;

    modport slave (
        input  enable, req_valid, req_grade, req_polyn, req_data, red_out, rsp_ready,
        output req_ready, red_enable, red_grade, red_polyn, red_reduc,
               rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output enable, req_valid, req_grade, req_polyn, req_data, red_out, rsp_ready,
        input  req_ready, red_enable, red_grade, red_polyn, red_reduc,
               rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/gf_reduce_sched.sv
// Round-robin scheduler sharing one registered GF(2^m) reduction datapath among NUM_REQ requesters.
// Define GF_RED_GRADE_CHECK_EN to reject out-of-range grades with an rsp_err response instead of issuing them.
module gf_reduce_sched #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LAT        = 2
) (
    input logic              clk,
    input logic              rst,
    gf_reduce_sched_if.slave bus
);
    localparam int GW = $clog2(DATA_WIDTH) + 1;
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(LAT + 1);
    localparam int PW = DATA_WIDTH + 1;
    localparam int RW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] ptr_reg, ptr_next;

    logic [GW-1:0] grade_s [NUM_REQ];
    logic [PW-1:0] polyn_s [NUM_REQ];
    logic [RW-1:0] data_s  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign grade_s[gi] = bus.req_grade[gi*GW +: GW];
            assign polyn_s[gi] = bus.req_polyn[gi*PW +: PW];
            assign data_s[gi]  = bus.req_data[gi*RW +: RW];
        end
    endgenerate

    logic          tag_valid [LAT];
    logic [IW-1:0] tag_id    [LAT];
    logic          tag_err   [LAT];
    logic [LW-1:0] inflight;

    logic [CW-1:0] count_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic          not_empty;

    // Round-robin search: first valid index at or after the pointer, wrapping.
    logic          found;
    logic [IW-1:0] winner;
    logic [IW-1:0] idx;
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(ptr_reg) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Every tag in the pipe already owns a FIFO slot, so no push can ever meet a full FIFO.
    logic room;
    logic grant;
    logic bad;
    logic issue;
    assign room  = (int'(count_reg) + int'(inflight)) < FIFO_DEPTH;
    assign grant = (state_reg == RUN) && bus.enable && room && found;

`ifdef GF_RED_GRADE_CHECK_EN
    assign bad = (int'(grade_s[winner]) < 2) || (int'(grade_s[winner]) > DATA_WIDTH);
`else
    assign bad = 1'b0;
`endif

    assign issue = grant && !bad;

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    assign bus.red_enable = (state_reg != IDLE);
    assign bus.red_grade  = issue ? grade_s[winner] : '0;
    assign bus.red_polyn  = issue ? polyn_s[winner] : '0;
    assign bus.red_reduc  = issue ? data_s[winner]  : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid[0] <= 1'b0;
            tag_id[0]    <= '0;
            tag_err[0]   <= 1'b0;
        end else begin
            tag_valid[0] <= grant;
            tag_id[0]    <= grant ? winner : '0;
            tag_err[0]   <= grant && bad;
        end
    end

    generate
        for (gi = 1; gi < LAT; gi++) begin : g_tag
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_valid[gi] <= 1'b0;
                    tag_id[gi]    <= '0;
                    tag_err[gi]   <= 1'b0;
                end else begin
                    tag_valid[gi] <= tag_valid[gi-1];
                    tag_id[gi]    <= tag_id[gi-1];
                    tag_err[gi]   <= tag_err[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight = inflight + LW'(tag_valid[k]);
        end
    end

    // Response FIFO: head is presented combinationally, outputs forced to 0 while empty.
    logic                  push, pop, do_push, full;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [IW-1:0]         mem_id   [FIFO_DEPTH];

    assign not_empty = (count_reg != '0);
    assign full      = (int'(count_reg) == FIFO_DEPTH);
    assign push      = tag_valid[LAT-1];
    assign push_data = tag_err[LAT-1] ? '0 : bus.red_out;
    assign pop       = not_empty && bus.rsp_ready;
    assign do_push   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr_reg] <= push_data;
            mem_id[wr_ptr_reg]   <= tag_id[LAT-1];
        end
    end

`ifdef GF_RED_GRADE_CHECK_EN
    logic mem_err [FIFO_DEPTH];
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_err[wr_ptr_reg] <= tag_err[LAT-1];
        end
    end
    assign bus.rsp_err = not_empty ? mem_err[rd_ptr_reg] : 1'b0;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!do_push && pop) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign bus.rsp_valid = not_empty;
    assign bus.rsp_data  = not_empty ? mem_data[rd_ptr_reg] : '0;
    assign bus.rsp_id    = not_empty ? mem_id[rd_ptr_reg] : '0;
    assign bus.busy      = (state_reg != IDLE) || (inflight != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE:    if (bus.enable) state_next = RUN;
            RUN:     if (!bus.enable) state_next = DRAIN;
            DRAIN:   if (inflight == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (grant) begin
            ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : IW'(int'(winner) + 1);
        end
    end
endmodule

// File: tb/tb_gf_reduce_sched.sv
// Directed bench for gf_reduce_sched with a behavioural 2-cycle reduction datapath and a response scoreboard.
`timescale 1ns/1ps
module tb_gf_reduce_sched;
    localparam int DW = 4;
    localparam int NR = 4;
    localparam int FD = 4;
    localparam int LT = 2;
    localparam int GW = $clog2(DW) + 1;
    localparam int IW = $clog2(NR);

`ifdef GF_RED_GRADE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gf_reduce_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    gf_reduce_sched #(
        .DATA_WIDTH(DW),
        .NUM_REQ(NR),
        .FIFO_DEPTH(FD),
        .LAT(LT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_xfer = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] gf_ref(input logic [2*DW-1:0] d, input logic [DW:0] p,
                                             input logic [GW-1:0] g);
        logic [2*DW-1:0] r;
        logic [2*DW-1:0] pe;
        if (int'(g) < 2 || int'(g) > DW) return '0;
        r  = d;
        pe = {{(DW-1){1'b0}}, p};
        for (int i = 2*DW-1; i >= 0; i--) begin
            if (i >= int'(g) && r[i]) r = r ^ (pe << (i - int'(g)));
        end
        return r[DW-1:0];
    endfunction

    // Behavioural datapath: two register stages, cleared while enable is low.
    logic [DW-1:0] dp_s1, dp_s2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_s1 <= '0;
            dp_s2 <= '0;
        end else if (!bus.red_enable) begin
            dp_s1 <= '0;
            dp_s2 <= '0;
        end else begin
            dp_s1 <= gf_ref(bus.red_reduc, bus.red_polyn, bus.red_grade);
            dp_s2 <= dp_s1;
        end
    end
    assign bus.red_out = dp_s2;

    logic [GW-1:0]   req_g [NR];
    logic [DW:0]     req_p [NR];
    logic [2*DW-1:0] req_d [NR];

    always_comb begin
        bus.req_grade = '0;
        bus.req_polyn = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_grade[i*GW +: GW]         = req_g[i];
            bus.req_polyn[i*(DW+1) +: (DW+1)] = req_p[i];
            bus.req_data[i*2*DW +: 2*DW]      = req_d[i];
        end
    end

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q_empty(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_rsp_valid(input string tag);
        int n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.rsp_valid), 32'd1);
    endtask

    // Monitor: push expectations on each transfer, compare on each response pop.
    logic [NR-1:0] mon_xfer;
    int            mon_id;
    logic          mon_bad;
    exp_t          mon_e;
    exp_t          mon_h;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_xfer = bus.req_valid & bus.req_ready;
                if (mon_xfer != '0) begin
                    mon_id = 0;
                    for (int i = 0; i < NR; i++) if (mon_xfer[i]) mon_id = i;
                    chk("grant_onehot", 32'($countones(bus.req_ready)), 32'd1);
                    mon_bad    = int'(req_g[mon_id]) < 2 || int'(req_g[mon_id]) > DW;
                    mon_e.id   = IW'(mon_id);
                    mon_e.err  = CHECK_EN && mon_bad;
                    mon_e.data = gf_ref(req_d[mon_id], req_p[mon_id], req_g[mon_id]);
                    exp_q.push_back(mon_e);
                    n_xfer++;
                    chk("red_reduc", 32'(bus.red_reduc), (CHECK_EN && mon_bad) ? 32'd0 : 32'(req_d[mon_id]));
                    chk("red_grade", 32'(bus.red_grade), (CHECK_EN && mon_bad) ? 32'd0 : 32'(req_g[mon_id]));
                end else begin
                    chk("red_idle", 32'(bus.red_reduc), 32'd0);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_h = exp_q.pop_front();
                        chk("rsp_id", 32'(bus.rsp_id), 32'(mon_h.id));
                        chk("rsp_data", 32'(bus.rsp_data), 32'(mon_h.data));
                        chk("rsp_err", 32'(bus.rsp_err), 32'(mon_h.err));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int t0;
    int base;
    initial begin
        rst = 1'b1;
        bus.enable    = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_g[i] = 3'd4;
            req_p[i] = 5'b10011;
        end
        req_g[2] = 3'd3;
        req_p[2] = 5'b01011;
        req_d[0] = 8'h40;
        req_d[1] = 8'hFF;
        req_d[2] = 8'h13;
        req_d[3] = 8'hA5;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_red_enable", 32'(bus.red_enable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Round robin with all requesters valid
        bus.enable    = 1'b1;
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_no_grant", 32'(bus.req_ready), 32'd0);
        chk("idle_red_enable", 32'(bus.red_enable), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % NR)));
            chk("rr_red_enable", 32'(bus.red_enable), 32'd1);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_q_empty("rr_drain");

        // Single request latency
        @(posedge clk); #1;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("single_grant", 32'(bus.req_ready), 32'd1);
        chk("single_red_polyn", 32'(bus.red_polyn), 32'h13);
        chk("single_red_reduc", 32'(bus.red_reduc), 32'h40);
        t0 = cyc;
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_rsp_valid("single_rsp_timeout");
        chk("single_latency", 32'(cyc - t0), 32'd3);
        chk("single_id", 32'(bus.rsp_id), 32'd0);
        chk("single_data", 32'(bus.rsp_data), 32'hC);
        wait_q_empty("single_drain");

        // Backpressure: FIFO fills, then one pop admits exactly one grant
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        base = n_xfer;
        repeat (10) @(negedge clk);
        chk("bp_grants", 32'(n_xfer - base), 32'(FD));
        chk("bp_stall_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_head_id", 32'(bus.rsp_id), 32'd1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        base = n_xfer;
        repeat (6) @(negedge clk);
        chk("bp_one_more", 32'(n_xfer - base), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_q_empty("bp_drain");

        // Enable dropped with two tags in flight
        @(posedge clk); #1;
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("drop_g1", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        chk("drop_g2", 32'(bus.req_ready), 32'b1000);
        @(posedge clk); #1;
        bus.enable    = 1'b0;
        bus.req_valid = '0;
        base = n_xfer;
        @(negedge clk);
        chk("drop_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 4'hF;
        for (int n = 0; n < 20 && bus.busy; n++) @(negedge clk);
        chk("drop_idle_busy", 32'(bus.busy), 32'd0);
        chk("drop_red_enable", 32'(bus.red_enable), 32'd0);
        repeat (2) @(negedge clk);
        chk("drop_no_grants", 32'(n_xfer - base), 32'd0);
        wait_q_empty("drop_drain");

        // Asynchronous reset with three entries queued
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.enable    = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 4'hF;
        base = n_xfer;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        chk("rstmid_grants", 32'(n_xfer - base), 32'd3);
        chk("rstmid_valid_before", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("rstmid_idle_grant", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("rstmid_next_req0", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_q_empty("rstmid_drain");

        // Out-of-range grade on requester 1 between good neighbours
        req_g[1] = 3'd1;
        req_p[1] = 5'b00011;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0111;
        @(negedge clk);
        chk("bad_grant1", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        chk("bad_grant2", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        chk("bad_grant0", 32'(bus.req_ready), 32'b0001);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_rsp_valid("bad_rsp_timeout");
        chk("bad_id", 32'(bus.rsp_id), 32'd1);
        chk("bad_err", 32'(bus.rsp_err), 32'(CHECK_EN));
        chk("bad_data", 32'(bus.rsp_data), 32'd0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_q_empty("bad_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
